// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg
// Shared definitions for the multiply/divide unit: op encodings as seen on
// the EX-stage op bus, the sequencer state enum and default latencies.
package mdu_ctrl_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Op encodings; 6 and 7 are no-ops.
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdState_t;

  // Ops 0..3 are the multi-cycle ones; all have op[2] clear.
  function automatic logic isLongOp(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith
// Purely combinational multiply/divide datapath. The sequencer latches the
// result on the start edge and only exposes it after the modelled latency.
// Ports:
//   op     - MDU op code (only 0..3 produce a result, others give zero)
//   src_a  - rs operand (dividend for divides)
//   src_b  - rt operand (divisor for divides)
//   result - {hi, lo}; hi = upper/remainder, lo = lower/quotient
module mdu_arith
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [2*WIDTH-1:0] extA;
  logic [2*WIDTH-1:0] extB;
  logic [2*WIDTH-1:0] prodS;
  logic [2*WIDTH-1:0] prodU;
  logic [WIDTH-1:0]   quoS;
  logic [WIDTH-1:0]   remS;
  logic [WIDTH-1:0]   quoU;
  logic [WIDTH-1:0]   remU;
  logic               divByZero;
  logic               divOverflow;

  // Signed product is formed at double width from sign-extended operands so
  // the low half and the high half both come out of one multiplier.
  assign extA  = {{WIDTH{src_a[WIDTH-1]}}, src_a};
  assign extB  = {{WIDTH{src_b[WIDTH-1]}}, src_b};
  assign prodS = extA * extB;
  assign prodU = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};

  // SV signed division truncates toward zero and the remainder takes the
  // dividend's sign, which is exactly the architectural behaviour.
  assign quoS = $signed(src_a) / $signed(src_b);
  assign remS = $signed(src_a) % $signed(src_b);
  assign quoU = src_a / src_b;
  assign remU = src_a % src_b;

  assign divByZero   = (src_b == '0);
  assign divOverflow = (src_a == MIN_NEG) && (src_b == ALL_ONES);

  // Corner cases are muxed in explicitly so the raw divider output for a
  // zero divisor or the overflowing signed case never reaches HI/LO.
  always_comb begin
    result = '0;
    case (op)
      MD_MULT:  result = prodS;
      MD_MULTU: result = prodU;
      MD_DIV: begin
        if (divByZero)        result = {src_a, ALL_ONES};
        else if (divOverflow) result = {{WIDTH{1'b0}}, MIN_NEG};
        else                  result = {remS, quoS};
      end
      MD_DIVU: begin
        if (divByZero) result = {src_a, ALL_ONES};
        else           result = {remU, quoU};
      end
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl
// Multi-cycle multiply/divide sequencer owning the HI/LO pair. The result is
// computed on the start edge but held in pending registers until the op's
// latency has elapsed, then committed to HI/LO. While busy it asks the
// hazard unit to stall any ID-stage instruction that touches the MDU.
// Ports:
//   clk, reset - clock (rising edge) and asynchronous active-low reset
//   start, op  - EX-stage MDU instruction valid and op code
//   src_a/b    - forwarded rs/rt values
//   md_use_d   - ID-stage instruction uses the MDU
//   busy       - operation in flight
//   stall      - stall request to the hazard unit
//   hi, lo     - architectural HI/LO
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             md_use_d,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  mdState_t           state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   pendHi;
  logic [WIDTH-1:0]   pendLo;
  logic [2*WIDTH-1:0] arithResult;
  logic               isMult;

  mdu_arith #(.WIDTH(WIDTH)) uArith (
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .result (arithResult)
  );

  assign isMult = (op == MD_MULT) || (op == MD_MULTU);

  // Sequencer: IDLE accepts ops (long ops load the pending result and the
  // latency counter, MTHI/MTLO write straight through); BUSY counts down and
  // commits on the cnt==0 edge. Starts seen in BUSY are dropped, including
  // one arriving on the commit edge itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      pendHi <= '0;
      pendLo <= '0;
      busy   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (isLongOp(op)) begin
              pendHi <= arithResult[2*WIDTH-1:WIDTH];
              pendLo <= arithResult[WIDTH-1:0];
              cnt    <= isMult ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
              state  <= BUSY;
              busy   <= 1'b1;
            end else if (op == MD_MTHI) begin
              hi <= src_a;
            end else if (op == MD_MTLO) begin
              lo <= src_a;
            end
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            hi    <= pendHi;
            lo    <= pendLo;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stall is combinational so an MDU user in ID is held back in the very
  // cycle a long op is being started, before busy has risen.
  assign stall = md_use_d & (busy | (start & isLongOp(op)));

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl
// Directed-vector bench for mdu_ctrl with hand-computed expected values.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        mdUseD;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mdu_ctrl #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .src_a    (srcA),
    .src_b    (srcB),
    .md_use_d (mdUseD),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck DUT still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one start cycle (called just after a negedge) and drop start
  // shortly after the accepting edge.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a,
                               input logic [31:0] b);
    start = 1'b1;
    op    = o;
    srcA  = a;
    srcB  = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd7;
  endtask

  // Count negedges with busy high after a start; returns at the first
  // negedge with busy low. The bound makes a hung DUT show up as a bad count.
  task automatic waitIdle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  int n;
  int stallCount;

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    op     = 3'd7;
    srcA   = '0;
    srcB   = '0;
    mdUseD = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy",  {63'd0, busy},  64'd0);
    checkOutput("reset_stall", {63'd0, stall}, 64'd0);
    checkOutput("reset_hilo",  {hi, lo},       64'd0);
    reset = 1'b1;

    // MULT -2 * 3
    @(negedge clk);
    applyStimulus(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    waitIdle(n);
    checkOutput("mult_cycles", 64'(n), 64'd5);
    checkOutput("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

    // MULTU same operands
    applyStimulus(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
    waitIdle(n);
    checkOutput("multu_cycles", 64'(n), 64'd5);
    checkOutput("multu_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

    // DIV -7 / 2 -> q=-3, r=-1
    applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    waitIdle(n);
    checkOutput("div_cycles", 64'(n), 64'd10);
    checkOutput("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // DIV 7 / -2 -> q=-3, r=1
    applyStimulus(MD_DIV, 32'd7, 32'hFFFF_FFFE);
    waitIdle(n);
    checkOutput("div_negdivisor", {hi, lo}, 64'h0000_0001_FFFF_FFFD);

    // DIVU 100 / 7 -> q=14, r=2
    applyStimulus(MD_DIVU, 32'd100, 32'd7);
    waitIdle(n);
    checkOutput("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

    // DIVU by zero
    applyStimulus(MD_DIVU, 32'h0000_1234, 32'd0);
    waitIdle(n);
    checkOutput("divu_zero", {hi, lo}, 64'h0000_1234_FFFF_FFFF);

    // DIV by zero with a negative dividend
    applyStimulus(MD_DIV, 32'h8000_0005, 32'd0);
    waitIdle(n);
    checkOutput("div_zero", {hi, lo}, 64'h8000_0005_FFFF_FFFF);

    // DIV overflow
    applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle(n);
    checkOutput("div_overflow", {hi, lo}, 64'h0000_0000_8000_0000);

    // Stall with an MDU user in ID: start cycle plus all 5 busy cycles
    mdUseD = 1'b1;
    start  = 1'b1;
    op     = MD_MULT;
    srcA   = 32'd6;
    srcB   = 32'd7;
    #1;
    checkOutput("stall_startcycle", {63'd0, stall}, 64'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd7;
    stallCount = 0;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      if (stall) stallCount++;
      n++;
      @(negedge clk);
    end
    checkOutput("stall_busycycles", 64'(stallCount), 64'd5);
    checkOutput("stall_afterbusy", {63'd0, stall}, 64'd0);
    checkOutput("stall_mult_hilo", {hi, lo}, 64'd42);

    // No MDU user in ID: stall never rises
    mdUseD = 1'b0;
    start  = 1'b1;
    op     = MD_MULT;
    srcA   = 32'd3;
    srcB   = 32'd3;
    #1;
    stallCount = stall ? 1 : 0;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd7;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      if (stall) stallCount++;
      n++;
      @(negedge clk);
    end
    checkOutput("nostall_count", 64'(stallCount), 64'd0);

    // MTLO in IDLE: visible next cycle, busy stays low
    applyStimulus(MD_MTLO, 32'h1234_5678, 32'd0);
    checkOutput("mtlo_lo",   {32'd0, lo},   64'h1234_5678);
    checkOutput("mtlo_busy", {63'd0, busy}, 64'd0);
    checkOutput("mtlo_hi",   {32'd0, hi},   64'd0);

    // MTHI in IDLE
    @(negedge clk);
    applyStimulus(MD_MTHI, 32'hCAFE_0001, 32'd0);
    checkOutput("mthi_hi", {hi, lo}, 64'hCAFE_0001_1234_5678);

    // MTHI while BUSY is ignored; 0x10000*0x30000 = 0x3_0000_0000
    @(negedge clk);
    applyStimulus(MD_MULTU, 32'h0001_0000, 32'h0003_0000);
    @(negedge clk);
    applyStimulus(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
    checkOutput("mthi_busy_hi", {32'd0, hi}, 64'hCAFE_0001);
    checkOutput("mthi_busy_stillbusy", {63'd0, busy}, 64'd1);
    waitIdle(n);
    checkOutput("mthi_busy_final", {hi, lo}, 64'h0000_0003_0000_0000);

    // Reset asserted during a DIV aborts immediately
    applyStimulus(MD_DIVU, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", {63'd0, busy}, 64'd0);
    checkOutput("abort_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_stayidle", {63'd0, busy}, 64'd0);
    applyStimulus(MD_MULT, 32'd6, 32'd7);
    waitIdle(n);
    checkOutput("postreset_cycles", 64'(n), 64'd5);
    checkOutput("postreset_hilo", {hi, lo}, 64'd42);

    // Back-to-back: DIV accepted in the first busy=0 cycle after a MULT
    applyStimulus(MD_MULT, 32'd9, 32'd9);
    waitIdle(n);
    checkOutput("b2b_mult_lo", {hi, lo}, 64'd81);
    applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    checkOutput("b2b_div_accepted", {63'd0, busy}, 64'd1);
    waitIdle(n);
    checkOutput("b2b_div_cycles", 64'(n), 64'd10);
    checkOutput("b2b_div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // Start on the commit edge is ignored
    applyStimulus(MD_MULTU, 32'd2, 32'd3);
    repeat (5) @(negedge clk);
    checkOutput("commit_prebusy", {63'd0, busy}, 64'd1);
    applyStimulus(MD_DIVU, 32'd9, 32'd0);
    checkOutput("commit_start_busy", {63'd0, busy}, 64'd0);
    checkOutput("commit_start_hilo", {hi, lo}, 64'd6);
    repeat (3) @(negedge clk);
    checkOutput("commit_start_later", {hi, lo, 31'd0, busy} == {64'd6, 32'd0} ? 64'd1 : 64'd0, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
